req_arbiter4: RTL and testbench
===============================

# req_arbiter4

Four-requester arbiter that shares one downstream resource, such as a bus slot or a shared encoder/datapath port, between four clients. A 4-bit priority encoder picks the winner, over either the raw request vector (fixed priority) or a rotated one (round-robin). The block holds a registered one-hot grant until the owner finishes, drops its request, or exceeds a maximum tenure. It sits between the request sources and the mux select of the shared resource.

## Interface
- ROUND_ROBIN, 1: 1 = rotating priority; 0 = fixed priority, req_in[3] highest.
- HOLD_MAX, 16: maximum grant tenure in cycles. 0 disables the timeout. Legal range 0–255.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low.
- req_in  input  4  per-requester request level. Must be held until granted.
- done_in  input  1  current owner signals end of transaction. Ignored when no grant is active.
- grant_out  output  4  one-hot grant, registered. All zero when idle.
- grant_id_out  output  2  index of the granted requester, registered.
- grant_valid_out  output  1  high while any grant is active.
- timeout_out  output  1  one-cycle pulse when a grant is revoked by timeout.

## Operation
- FSM has two states: IDLE and GRANT. Reset state is IDLE.
- Reset values:
  - grant_out = 4'b0000, grant_id_out = 2'b00.
  - grant_valid_out = 0, timeout_out = 0.
  - Internal last_id = 2'd0 and hold counter = 0.
- Arbitration runs only in IDLE.
- Fixed mode: req_in feeds the encoder directly. Priority is bit 3 > 2 > 1 > 0.
- Round-robin mode: the search starts at index (last_id − 1) mod 4 and descends with wrap-around. Examples: last_id = 2 gives order 1, 0, 3, 2; last_id = 0 (the reset value) gives order 3, 2, 1, 0, identical to fixed mode.
- IDLE → GRANT when req_in != 0 at a rising edge. On that edge:
  - grant_out loads the one-hot winner, grant_id_out loads its index, grant_valid_out goes to 1.
  - last_id loads the winner index and the hold counter loads 1.
- In GRANT, req_in of non-owners is ignored. There is no preemption.
- The hold counter increments every GRANT cycle and saturates at 255.
- GRANT → IDLE at the first rising edge where any release condition holds:
  - (a) done_in = 1;
  - (b) req_in[grant_id_out] = 0;
  - (c) HOLD_MAX != 0 and the hold counter == HOLD_MAX.
- On that edge grant_out = 0 and grant_valid_out = 0. grant_id_out keeps its last value.
- timeout_out = 1 for the cycle after the edge only when (c) is the sole cause. If (a) or (b) is also true in the same cycle, it is a normal release with no timeout pulse.
- Invariants:
  - grant_out is always one-hot or zero.
  - grant_valid_out = |grant_out.
  - grant_out[grant_id_out] = 1 whenever valid.

## Timing
- Grant latency: a request sampled at edge k (FSM in IDLE) produces a grant visible after edge k, one cycle of registered latency.
- Release: a condition sampled at edge k produces a deasserted grant after edge k.
- At least one IDLE cycle always separates consecutive grants. There are no back-to-back grants.
- Maximum tenure is exactly HOLD_MAX cycles of grant_valid_out = 1.
- Worst-case wait for a persistently requesting client in round-robin mode: 3 × (HOLD_MAX + 1) + 1 cycles.
- Requests that appear during GRANT are arbitrated at the first IDLE edge.
- Deassertion of rst_n mid-grant is asynchronous: all outputs clear immediately and the FSM returns to IDLE with last_id = 0. Arbitration resumes at the first rising edge after rst_n rises.

## Test plan
- Reset check: rst_n = 0 with req_in = 4'b1111 → all outputs 0. Release reset → after the next edge, grant_out = 4'b1000, grant_id_out = 3.
- Fixed priority (ROUND_ROBIN = 0): hold req_in = 4'b0110 and pulse done_in one cycle per grant → grants repeat 4'b0100, idle, 4'b0100, …; requester 1 is never served.
- Round-robin rotation: hold req_in = 4'b1111 and pulse done_in on each grant's first cycle → grant_id_out sequence 3, 2, 1, 0, 3, each grant separated by one idle cycle.
- Timeout (HOLD_MAX = 4): req_in = 4'b0001 held and done_in = 0 → grant_valid_out high for exactly 4 cycles. timeout_out pulses once; regrant follows after one idle cycle.
- Simultaneous events (HOLD_MAX = 4): done_in = 1 in the 4th grant cycle → release with timeout_out = 0. Separately, dropping the owner's req_in mid-grant → release on the next edge.
- Async reset mid-grant: assert rst_n = 0 between clock edges while grant_out = 4'b0010 → outputs clear without waiting for an edge. The first post-reset grant uses the order 3, 2, 1, 0.

Source files
------------

// File: rtl/req_arbiter4.sv
// Four-requester arbiter: fixed or round-robin priority pick in IDLE, registered
// one-hot grant held until done, request drop, or HOLD_MAX-cycle tenure expiry.
module req_arbiter4 #(
    parameter bit          ROUND_ROBIN = 1'b1,
    parameter int unsigned HOLD_MAX    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req_in,
    input  logic       done_in,
    output logic [3:0] grant_out,
    output logic [1:0] grant_id_out,
    output logic       grant_valid_out,
    output logic       timeout_out
);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [3:0] r_grant, w_grant_nxt;
    logic [1:0] r_id, w_id_nxt;
    logic [1:0] r_last_id, w_last_nxt;
    logic [7:0] r_hold, w_hold_nxt;
    logic       r_tmo, w_tmo_nxt;

    logic       w_found;
    logic [1:0] w_win;
    logic [1:0] w_start;
    logic       w_norm_rel;
    logic       w_to_hit;

    // Search begins one below the previous winner and descends with wrap-around;
    // fixed mode is the same search anchored at index 3.
    assign w_start = ROUND_ROBIN ? (r_last_id - 2'd1) : 2'd3;

    always_comb begin
        logic [1:0] idx;
        w_found = 1'b0;
        w_win   = 2'd0;
        idx     = 2'd0;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = w_start - 2'(i);
            if (!w_found && req_in[idx]) begin
                w_found = 1'b1;
                w_win   = idx;
            end
        end
    end

    assign w_norm_rel = done_in | ~req_in[r_id];
    assign w_to_hit   = (HOLD_MAX != 0) && (r_hold == 8'(HOLD_MAX));

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_id_nxt    = r_id;
        w_last_nxt  = r_last_id;
        w_hold_nxt  = r_hold;
        w_tmo_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt        = S_GRANT;
                    w_grant_nxt        = '0;
                    w_grant_nxt[w_win] = 1'b1;
                    w_id_nxt           = w_win;
                    w_last_nxt         = w_win;
                    w_hold_nxt         = 8'd1;
                end
            end
            S_GRANT: begin
                if (r_hold != 8'hFF) begin
                    w_hold_nxt = r_hold + 8'd1;
                end
                if (w_norm_rel || w_to_hit) begin
                    w_state_nxt = S_IDLE;
                    w_grant_nxt = '0;
                    // Timeout is flagged only when expiry is the sole release cause.
                    w_tmo_nxt   = w_to_hit & ~w_norm_rel;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_id      <= '0;
            r_last_id <= '0;
            r_hold    <= '0;
            r_tmo     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_id      <= w_id_nxt;
            r_last_id <= w_last_nxt;
            r_hold    <= w_hold_nxt;
            r_tmo     <= w_tmo_nxt;
        end
    end

    assign grant_out       = r_grant;
    assign grant_id_out    = r_id;
    assign grant_valid_out = |r_grant;
    assign timeout_out     = r_tmo;

endmodule

// File: tb/tb_req_arbiter4.sv
// Bench for req_arbiter4: three parameterisations share one directed stimulus and
// are compared every cycle against a transaction-level model plus literal checks.
module tb_req_arbiter4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req   = 4'b0000;
    logic       done  = 1'b0;

    logic [3:0] g   [3];
    logic [1:0] gid [3];
    logic       gv  [3];
    logic       gt  [3];

    int checks = 0;
    int errors = 0;

    // DUT 0: round-robin, HOLD_MAX=4; DUT 1: fixed, HOLD_MAX=4; DUT 2: round-robin, no timeout
    localparam int P_RR [3] = '{1, 0, 1};
    localparam int P_HM [3] = '{4, 4, 0};

    req_arbiter4 #(.ROUND_ROBIN(1'b1), .HOLD_MAX(4)) u_rr (
        .clk(clk), .rst_n(rst_n), .req_in(req), .done_in(done),
        .grant_out(g[0]), .grant_id_out(gid[0]), .grant_valid_out(gv[0]), .timeout_out(gt[0]));
    req_arbiter4 #(.ROUND_ROBIN(1'b0), .HOLD_MAX(4)) u_fix (
        .clk(clk), .rst_n(rst_n), .req_in(req), .done_in(done),
        .grant_out(g[1]), .grant_id_out(gid[1]), .grant_valid_out(gv[1]), .timeout_out(gt[1]));
    req_arbiter4 #(.ROUND_ROBIN(1'b1), .HOLD_MAX(0)) u_nto (
        .clk(clk), .rst_n(rst_n), .req_in(req), .done_in(done),
        .grant_out(g[2]), .grant_id_out(gid[2]), .grant_valid_out(gv[2]), .timeout_out(gt[2]));

    always #5 clk = ~clk;

    typedef struct {
        int owner;   // -1 when nobody holds the resource
        int id;
        int last;
        int tenure;  // cycles the current owner has held the grant
        bit tmo;
    } mstate_t;

    mstate_t m [3];

    function automatic int pick_fixed(input logic [3:0] r);
        for (int i = 3; i >= 0; i--) if (r[i]) return i;
        return -1;
    endfunction

    function automatic int pick_rr(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            int idx = (last - k + 8) % 4;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic mstate_t step(input mstate_t s, input int d, input logic [3:0] r, input logic dn);
        mstate_t n = s;
        n.tmo = 1'b0;
        if (s.owner < 0) begin
            if (r != 4'b0000) begin
                int w = (P_RR[d] != 0) ? pick_rr(r, s.last) : pick_fixed(r);
                n.owner  = w;
                n.id     = w;
                n.last   = w;
                n.tenure = 1;
            end
        end else begin
            bit expired = (P_HM[d] != 0) && (s.tenure == P_HM[d]);
            bit normal  = dn || !r[s.owner];
            if (expired || normal) begin
                n.owner = -1;
                n.tmo   = expired && !normal;
            end
            n.tenure = (s.tenure < 255) ? s.tenure + 1 : 255;
        end
        return n;
    endfunction

    function automatic logic [3:0] exp_grant(input int owner);
        logic [3:0] e = 4'b0000;
        if (owner >= 0) e[owner] = 1'b1;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 3; d++) begin
            if (!rst_n) m[d] <= '{owner: -1, id: 0, last: 0, tenure: 0, tmo: 1'b0};
            else        m[d] <= step(m[d], d, req, done);
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("d%0d grant", d), 32'(g[d]), 32'(exp_grant(m[d].owner)));
            chk($sformatf("d%0d grant_id", d), 32'(gid[d]), 32'(m[d].id));
            chk($sformatf("d%0d valid", d), 32'(gv[d]), 32'(m[d].owner >= 0));
            chk($sformatf("d%0d timeout", d), 32'(gt[d]), 32'(m[d].tmo));
            chk($sformatf("d%0d onehot", d), 32'($countones(g[d]) <= 1), 32'd1);
        end
    end

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    initial begin
        int ids [4] = '{2, 1, 0, 3};
        int c0100, c0010, rr1;
        logic [6:0] vpat0, tpat0, vpat2, tpat2;

        // Reset with all requests asserted
        req = 4'b1111;
        repeat (3) nxt();
        for (int d = 0; d < 3; d++) begin
            chk("reset grant", 32'(g[d]), 32'h0);
            chk("reset valid", 32'(gv[d]), 32'h0);
            chk("reset id", 32'(gid[d]), 32'h0);
            chk("reset timeout", 32'(gt[d]), 32'h0);
        end
        rst_n = 1'b1;
        nxt();
        for (int d = 0; d < 3; d++) begin
            chk("first grant", 32'(g[d]), 32'h8);
            chk("first id", 32'(gid[d]), 32'd3);
        end

        // Round-robin rotation: done held high releases every grant after one cycle
        done = 1'b1;
        for (int n = 0; n < 4; n++) begin
            nxt();
            chk("rr gap", 32'(gv[0]), 32'h0);
            nxt();
            chk("rr id seq", 32'(gid[0]), 32'(ids[n]));
            chk("fixed id seq", 32'(gid[1]), 32'd3);
        end

        // Fixed priority starves requester 1
        req = 4'b0110;
        c0100 = 0; c0010 = 0; rr1 = 0;
        repeat (8) begin
            nxt();
            if (g[1] == 4'b0100) c0100++;
            if (g[1] == 4'b0010) c0010++;
            if (gv[0] && gid[0] == 2'd1) rr1++;
        end
        chk("fixed grants of req2", 32'(c0100), 32'd4);
        chk("fixed grants of req1", 32'(c0010), 32'd0);
        chk("rr grants of req1", 32'(rr1), 32'd2);

        // Timeout: single persistent requester, no done
        done = 1'b0;
        req  = 4'b0001;
        vpat0 = '0; tpat0 = '0; vpat2 = '0; tpat2 = '0;
        for (int n = 0; n < 7; n++) begin
            nxt();
            vpat0 = {vpat0[5:0], gv[0]};
            tpat0 = {tpat0[5:0], gt[0]};
            vpat2 = {vpat2[5:0], gv[2]};
            tpat2 = {tpat2[5:0], gt[2]};
        end
        chk("tenure valid pattern", 32'(vpat0), 32'(7'b0111101));
        chk("tenure timeout pattern", 32'(tpat0), 32'(7'b0000010));
        chk("no-timeout valid pattern", 32'(vpat2), 32'(7'b0111111));
        chk("no-timeout timeout pattern", 32'(tpat2), 32'(7'b0000000));

        // done in the 4th grant cycle coincides with expiry: plain release
        repeat (3) nxt();
        done = 1'b1;
        nxt();
        chk("coincident release valid", 32'(gv[0]), 32'h0);
        chk("coincident release timeout", 32'(gt[0]), 32'h0);
        done = 1'b0;
        nxt();
        chk("regrant", 32'(gv[0]), 32'h1);
        nxt();
        req = 4'b0000;
        nxt();
        chk("req drop release", 32'(gv[0]), 32'h0);
        chk("req drop timeout", 32'(gt[0]), 32'h0);

        // Async reset in the middle of a grant to requester 1
        req = 4'b0010;
        nxt();
        chk("pre-reset grant", 32'(g[0]), 32'h2);
        #1 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("async clear grant", 32'(g[d]), 32'h0);
            chk("async clear valid", 32'(gv[d]), 32'h0);
            chk("async clear id", 32'(gid[d]), 32'h0);
        end
        req = 4'b0101;
        repeat (2) nxt();
        rst_n = 1'b1;
        nxt();
        chk("post-reset rr grant", 32'(g[0]), 32'h4);
        chk("post-reset rr id", 32'(gid[0]), 32'd2);
        chk("post-reset fixed grant", 32'(g[1]), 32'h4);
        repeat (2) nxt();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
